cache_ctrl: RTL and testbench

Sequencing controller between the bf8b core's data port, the LRU `cache` block and the backing data memory. It serialises core requests, performs the cache lookup, and on a read miss fetches the byte from memory and fills the cache. Writes go through to memory (write-through, write-allocate), and the shift (settle) cycle the cache needs after every hit or fill is inserted automatically. It also keeps saturating hit/miss statistics.

---
 rtl/cache_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 22 ++
 rtl/cache_ctrl.sv | 144 ++++++++++++++
 tb/tb_cache_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the cache sequencing controller and the LRU cache.
// The state enum is the controller's transaction sequence.
package cache_ctrl_pkg;

   localparam int unsigned CC_ADDR_WIDTH = 8;
   localparam int unsigned CC_DATA_WIDTH = 8;
   localparam int unsigned CC_CNT_WIDTH  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      CHECK  = 3'd2,
      MEM_RD = 3'd3,
      MEM_WR = 3'd4,
      FILL   = 3'd5,
      SETTLE = 3'd6,
      ACK    = 3'd7
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {WIDTH{1'b1}})) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Sequences core requests through cache lookup, memory fetch/write-through and cache fill,
// inserting the cache settle cycle after every hit or fill; keeps read hit/miss statistics.
module cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = CC_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = CC_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = CC_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cache_en,
   output logic                  cache_we,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   output logic [DATA_WIDTH-1:0] cache_wdata,
   input  logic [DATA_WIDTH-1:0] cache_rdata,
   input  logic                  cache_hit,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   input  logic                  cnt_clr,
   output logic [CNT_WIDTH-1:0]  hit_cnt,
   output logic [CNT_WIDTH-1:0]  miss_cnt
);

   state_e state;
   logic   hit_inc_c;
   logic   miss_inc_c;

   // Statistics only look at the lookup result, which is only meaningful in CHECK.
   assign hit_inc_c  = (state == CHECK) &&  cache_hit;
   assign miss_inc_c = (state == CHECK) && !cache_hit;

   // Outputs are registered with the state they belong to. cache_addr, mem_addr and
   // mem_wdata double as the latched request; cache_wdata doubles as the fill register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cpu_rdata   <= '0;
         cpu_ack     <= 1'b0;
         cache_en    <= 1'b0;
         cache_we    <= 1'b0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         cpu_ack  <= 1'b0;
         cache_en <= 1'b0;
         cache_we <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  cache_addr <= cpu_addr;
                  mem_addr   <= cpu_addr;
                  mem_wdata  <= cpu_wdata;
                  if (cpu_we) begin
                     state   <= MEM_WR;
                     mem_req <= 1'b1;
                     mem_we  <= 1'b1;
                  end else begin
                     state    <= LOOKUP;
                     cache_en <= 1'b1;
                  end
               end
            end
            LOOKUP: begin
               state <= CHECK;
            end
            CHECK: begin
               if (cache_hit) begin
                  cpu_rdata <= cache_rdata;
                  state     <= SETTLE;
               end else begin
                  state   <= MEM_RD;
                  mem_req <= 1'b1;
                  mem_we  <= 1'b0;
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  cpu_rdata   <= mem_rdata;
                  cache_wdata <= mem_rdata;
                  mem_req     <= 1'b0;
                  cache_en    <= 1'b1;
                  cache_we    <= 1'b1;
                  state       <= FILL;
               end
            end
            MEM_WR: begin
               if (mem_ack) begin
                  cache_wdata <= mem_wdata;
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  cache_en    <= 1'b1;
                  cache_we    <= 1'b1;
                  state       <= FILL;
               end
            end
            FILL: begin
               state <= SETTLE;
            end
            SETTLE: begin
               cpu_ack <= 1'b1;
               state   <= ACK;
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit_inc_c),
      .clr (cnt_clr),
      .q   (hit_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
      .clk (clk),
      .rst (rst),
      .inc (miss_inc_c),
      .clr (cnt_clr),
      .q   (miss_cnt)
   );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural LRU cache and memory around the DUT, with a queue-based
// reference model predicting hit/miss, latency, data and statistics.
module tb_cache_ctrl;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          cache_en;
   logic          cache_we;
   logic [AW-1:0] cache_addr;
   logic [DW-1:0] cache_wdata;
   logic [DW-1:0] cache_rdata = '0;
   logic          cache_hit = 1'b0;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] hit_cnt;
   logic [CW-1:0] miss_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .cache_en(cache_en), .cache_we(cache_we), .cache_addr(cache_addr),
      .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // ---------------- environment: backing memory ----------------
   logic [DW-1:0] mem_arr [256];
   bit            mem_wr_vld [256] = '{default: 1'b0};
   int            mem_delay = 0;
   int            wait_cnt = 0;
   logic          stray_ack = 1'b0;
   int            mem_wr_cnt = 0;
   logic [AW-1:0] last_wr_addr = '0;
   logic [DW-1:0] last_wr_data = '0;

   assign mem_ack   = (mem_req && (wait_cnt == mem_delay)) || stray_ack;
   assign mem_rdata = mem_wr_vld[mem_addr] ? mem_arr[mem_addr] : (mem_addr ^ 8'h4A);

   always @(posedge clk) begin
      if (mem_req && mem_ack && mem_we) begin
         mem_arr[mem_addr]    <= mem_wdata;
         mem_wr_vld[mem_addr] <= 1'b1;
         mem_wr_cnt           <= mem_wr_cnt + 1;
         last_wr_addr         <= mem_addr;
         last_wr_data         <= mem_wdata;
      end
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
   end

   // ---------------- environment: 4-cell LRU cache ----------------
   logic [AW-1:0] c_tag [4] = '{default: '0};
   logic [DW-1:0] c_dat [4] = '{default: '0};
   bit            c_vld [4] = '{default: 1'b0};
   int            c_stamp [4] = '{default: 0};
   int            cyc_ctr = 1;

   function automatic int c_find(input logic [AW-1:0] a);
      for (int i = 0; i < 4; i++) if (c_vld[i] && c_tag[i] == a) return i;
      return -1;
   endfunction

   function automatic int c_slot(input logic [AW-1:0] a);
      int v = 0;
      if (c_find(a) >= 0) return c_find(a);
      for (int i = 0; i < 4; i++) begin
         if (!c_vld[i]) return i;
         if (c_stamp[i] < c_stamp[v]) v = i;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      cyc_ctr <= cyc_ctr + 1;
      if (cache_en && !cache_we) begin
         if (c_find(cache_addr) >= 0) begin
            cache_hit                    <= 1'b1;
            cache_rdata                  <= c_dat[c_find(cache_addr)];
            c_stamp[c_find(cache_addr)]  <= cyc_ctr;
         end else begin
            cache_hit   <= 1'b0;
            cache_rdata <= '0;
         end
      end else if (cache_en && cache_we) begin
         c_tag[c_slot(cache_addr)]   <= cache_addr;
         c_dat[c_slot(cache_addr)]   <= cache_wdata;
         c_vld[c_slot(cache_addr)]   <= 1'b1;
         c_stamp[c_slot(cache_addr)] <= cyc_ctr;
      end
   end

   // ---------------- reference model ----------------
   logic [AW-1:0] ref_lru [$];
   logic [DW-1:0] ref_mem [256];
   bit            ref_wr [256] = '{default: 1'b0};
   int            ref_hits = 0;
   int            ref_miss = 0;
   logic [DW-1:0] ref_rdata = '0;

   function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
      return ref_wr[a] ? ref_mem[a] : (a ^ 8'h4A);
   endfunction

   task automatic ref_touch(input logic [AW-1:0] a);
      for (int i = 0; i < ref_lru.size(); i++) begin
         if (ref_lru[i] == a) begin
            ref_lru.delete(i);
            break;
         end
      end
      ref_lru.push_front(a);
      if (ref_lru.size() > 4) void'(ref_lru.pop_back());
   endtask

   task automatic ref_read(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
      hit = 1'b0;
      foreach (ref_lru[i]) if (ref_lru[i] == a) hit = 1'b1;
      d = ref_val(a);
      ref_rdata = d;
      if (hit) ref_hits = (ref_hits < (1 << CW) - 1) ? ref_hits + 1 : ref_hits;
      else     ref_miss = (ref_miss < (1 << CW) - 1) ? ref_miss + 1 : ref_miss;
      ref_touch(a);
   endtask

   task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ref_mem[a] = d;
      ref_wr[a]  = 1'b1;
      ref_touch(a);
   endtask

   // One full core transaction; returns cycle numbers (cycle 0 = IDLE sample cycle), -1 if absent.
   task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int delay, input int clr_at, output int ack_cyc, output int mreq_cyc);
      @(negedge clk);
      mem_delay = delay;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      ack_cyc   = -1;
      mreq_cyc  = -1;
      for (int c = 1; c <= 60 && ack_cyc < 0; c++) begin
         @(posedge clk); #1;
         cnt_clr = (c == clr_at);
         if (mem_req && mreq_cyc < 0) mreq_cyc = c;
         if (cpu_ack) begin
            ack_cyc = c;
            cpu_req = 1'b0;
         end
      end
      cnt_clr = 1'b0;
      cpu_req = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (cpu_ack !== 1'b0)  begin bad++; $display("FAIL reset_cpu_ack: got %0b want 0", cpu_ack); end
      total++; if (mem_req !== 1'b0)  begin bad++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
      total++; if ({cache_en, cache_we, mem_we} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {cache_en, cache_we, mem_we}); end
      total++; if (cpu_rdata !== '0)  begin bad++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
      total++; if ({hit_cnt, miss_cnt} !== '0) begin bad++; $display("FAIL reset_counters: got %h/%h want 0/0", hit_cnt, miss_cnt); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_read_miss();
      bit h; logic [DW-1:0] d; int ack, mr;
      ref_read(8'h10, h, d);
      run_txn(1'b0, 8'h10, 8'h00, 0, -1, ack, mr);
      total++; if (mr !== 3)          begin bad++; $display("FAIL miss_mem_req_cycle: got %0d want 3", mr); end
      total++; if (ack !== 6)         begin bad++; $display("FAIL miss_ack_cycle: got %0d want 6", ack); end
      total++; if (cpu_rdata !== d)   begin bad++; $display("FAIL miss_rdata: got %h want %h", cpu_rdata, d); end
      total++; if (cpu_rdata !== 8'h5A) begin bad++; $display("FAIL miss_rdata_5a: got %h want 5a", cpu_rdata); end
      total++; if (miss_cnt !== CW'(ref_miss)) begin bad++; $display("FAIL miss_cnt: got %0d want %0d", miss_cnt, ref_miss); end
   endtask

   task automatic test_read_hit();
      bit h; logic [DW-1:0] d; int ack, mr;
      ref_read(8'h10, h, d);
      run_txn(1'b0, 8'h10, 8'h00, 0, -1, ack, mr);
      total++; if (mr !== -1)         begin bad++; $display("FAIL hit_no_mem_req: got %0d want -1", mr); end
      total++; if (ack !== 4)         begin bad++; $display("FAIL hit_ack_cycle: got %0d want 4", ack); end
      total++; if (cpu_rdata !== d)   begin bad++; $display("FAIL hit_rdata: got %h want %h", cpu_rdata, d); end
      total++; if (hit_cnt !== CW'(ref_hits)) begin bad++; $display("FAIL hit_cnt: got %0d want %0d", hit_cnt, ref_hits); end
   endtask

   task automatic test_write_through();
      bit h; logic [DW-1:0] d; int ack, mr, wr0;
      wr0 = mem_wr_cnt;
      ref_write(8'h20, 8'h33);
      run_txn(1'b1, 8'h20, 8'h33, 3, -1, ack, mr);
      total++; if (mr !== 1)          begin bad++; $display("FAIL wr_mem_req_cycle: got %0d want 1", mr); end
      total++; if (ack !== 7)         begin bad++; $display("FAIL wr_ack_cycle: got %0d want 7", ack); end
      total++; if (mem_wr_cnt !== wr0 + 1 || last_wr_addr !== 8'h20 || last_wr_data !== 8'h33)
         begin bad++; $display("FAIL wr_mem_seen: got n=%0d a=%h d=%h want n=%0d a=20 d=33", mem_wr_cnt - wr0, last_wr_addr, last_wr_data, 1); end
      total++; if (cpu_rdata !== ref_rdata) begin bad++; $display("FAIL wr_rdata_held: got %h want %h", cpu_rdata, ref_rdata); end
      ref_read(8'h20, h, d);
      run_txn(1'b0, 8'h20, 8'h00, 0, -1, ack, mr);
      total++; if (ack !== 4 || mr !== -1) begin bad++; $display("FAIL wr_then_hit_timing: got ack=%0d mreq=%0d want ack=4 mreq=-1", ack, mr); end
      total++; if (cpu_rdata !== 8'h33) begin bad++; $display("FAIL wr_then_hit_rdata: got %h want 33", cpu_rdata); end
   endtask

   task automatic test_eviction();
      bit h; logic [DW-1:0] d; int ack, mr;
      for (int i = 0; i < 5; i++) begin
         ref_read(AW'(8'h40 + i), h, d);
         run_txn(1'b0, AW'(8'h40 + i), 8'h00, 0, -1, ack, mr);
         total++; if (cpu_rdata !== d) begin bad++; $display("FAIL evict_fill_rdata[%0d]: got %h want %h", i, cpu_rdata, d); end
      end
      ref_read(8'h40, h, d);
      run_txn(1'b0, 8'h40, 8'h00, 1, -1, ack, mr);
      total++; if (h !== 1'b0 || mr !== 3) begin bad++; $display("FAIL evict_refetch: got mreq=%0d want 3 (model hit=%0b)", mr, h); end
      total++; if (ack !== 7)         begin bad++; $display("FAIL evict_ack_cycle: got %0d want 7", ack); end
      total++; if (cpu_rdata !== d)   begin bad++; $display("FAIL evict_rdata: got %h want %h", cpu_rdata, d); end
      total++; if (miss_cnt !== CW'(ref_miss)) begin bad++; $display("FAIL evict_miss_cnt: got %0d want %0d", miss_cnt, ref_miss); end
   endtask

   task automatic test_reset_mid_fetch();
      bit h; logic [DW-1:0] d; int ack, mr;
      @(negedge clk);
      mem_delay = 20;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
      end
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_in_mem_rd: got %0b want 1", mem_req); end
      #2 rst = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0)  begin bad++; $display("FAIL rstmid_mem_req_async: got %0b want 0", mem_req); end
      total++; if ({hit_cnt, miss_cnt} !== '0) begin bad++; $display("FAIL rstmid_counters: got %h/%h want 0/0", hit_cnt, miss_cnt); end
      total++; if (cpu_rdata !== '0 || mem_addr !== '0 || cache_addr !== '0)
         begin bad++; $display("FAIL rstmid_data_regs: got rd=%h ma=%h ca=%h want 0", cpu_rdata, mem_addr, cache_addr); end
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      ref_hits = 0; ref_miss = 0; ref_rdata = '0;
      ref_read(8'h50, h, d);
      run_txn(1'b0, 8'h50, 8'h00, 1, -1, ack, mr);
      total++; if (ack !== 7 || mr !== 3) begin bad++; $display("FAIL rstmid_next_read_timing: got ack=%0d mreq=%0d want ack=7 mreq=3", ack, mr); end
      total++; if (cpu_rdata !== d)   begin bad++; $display("FAIL rstmid_next_read_rdata: got %h want %h", cpu_rdata, d); end
      total++; if (miss_cnt !== CW'(ref_miss)) begin bad++; $display("FAIL rstmid_miss_cnt: got %0d want %0d", miss_cnt, ref_miss); end
   endtask

   task automatic test_stray_ack();
      bit h; logic [DW-1:0] d; int ack, mr;
      stray_ack = 1'b1;
      ref_read(8'h50, h, d);
      run_txn(1'b0, 8'h50, 8'h00, 0, -1, ack, mr);
      stray_ack = 1'b0;
      total++; if (ack !== 4 || mr !== -1) begin bad++; $display("FAIL stray_ack_timing: got ack=%0d mreq=%0d want ack=4 mreq=-1", ack, mr); end
      total++; if (cpu_rdata !== d)   begin bad++; $display("FAIL stray_ack_rdata: got %h want %h", cpu_rdata, d); end
   endtask

   task automatic test_saturation();
      bit h; logic [DW-1:0] d; int ack, mr;
      for (int i = 0; i < 16; i++) begin
         ref_read(8'h50, h, d);
         run_txn(1'b0, 8'h50, 8'h00, 0, -1, ack, mr);
         total++; if (ack !== 4) begin bad++; $display("FAIL sat_hit_ack[%0d]: got %0d want 4", i, ack); end
      end
      total++; if (hit_cnt !== CW'(ref_hits)) begin bad++; $display("FAIL sat_hit_cnt_model: got %0d want %0d", hit_cnt, ref_hits); end
      total++; if (hit_cnt !== {CW{1'b1}}) begin bad++; $display("FAIL sat_hit_cnt_allones: got %h want %h", hit_cnt, {CW{1'b1}}); end
   endtask

   task automatic test_clr_with_hit();
      bit h; logic [DW-1:0] d; int ack, mr;
      ref_read(8'h50, h, d);
      run_txn(1'b0, 8'h50, 8'h00, 0, 2, ack, mr);
      ref_hits = 0;
      ref_miss = 0;
      total++; if (hit_cnt !== '0)    begin bad++; $display("FAIL clr_wins_hit_cnt: got %0d want 0", hit_cnt); end
      total++; if (miss_cnt !== '0)   begin bad++; $display("FAIL clr_miss_cnt: got %0d want 0", miss_cnt); end
      total++; if (ack !== 4)         begin bad++; $display("FAIL clr_hit_ack: got %0d want 4", ack); end
   endtask

   task automatic test_back_to_back();
      bit h; logic [DW-1:0] d; logic [AW-1:0] a; logic [DW-1:0] wd; logic we;
      int ack, mr, dl, exp_ack, exp_mr;
      for (int n = 0; n < 40; n++) begin
         a  = AW'(8'h60 + $urandom_range(0, 6));
         wd = DW'($urandom_range(0, 255));
         we = ($urandom_range(0, 2) == 0);
         dl = $urandom_range(0, 3);
         if (we) begin
            ref_write(a, wd);
            exp_ack = 4 + dl;
            exp_mr  = 1;
         end else begin
            ref_read(a, h, d);
            exp_ack = h ? 4 : 6 + dl;
            exp_mr  = h ? -1 : 3;
         end
         run_txn(we, a, wd, dl, -1, ack, mr);
         total++; if (ack !== exp_ack) begin bad++; $display("FAIL rand_ack[%0d]: got %0d want %0d", n, ack, exp_ack); end
         total++; if (mr !== exp_mr)   begin bad++; $display("FAIL rand_mem_req[%0d]: got %0d want %0d", n, mr, exp_mr); end
         total++; if (cpu_rdata !== ref_rdata) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, cpu_rdata, ref_rdata); end
         total++; if (hit_cnt !== CW'(ref_hits) || miss_cnt !== CW'(ref_miss))
            begin bad++; $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", n, hit_cnt, miss_cnt, ref_hits, ref_miss); end
         if (we) begin
            total++; if (last_wr_addr !== a || last_wr_data !== wd)
               begin bad++; $display("FAIL rand_mem_write[%0d]: got %h@%h want %h@%h", n, last_wr_data, last_wr_addr, wd, a); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_through();
      test_eviction();
      test_reset_mid_fetch();
      test_stray_ack();
      test_saturation();
      test_clr_with_hit();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
      $fatal(1);
   end

endmodule
